// File: rtl/ins_memory_pipe_if.sv
// Loader and IF-stage bus for ins_memory_pipe.
// The master drives load/fetch requests; the slave is the memory.
interface ins_memory_pipe_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DEPTH  = 16
);
  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic              ld_we;
  logic [IDX_W-1:0]  ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_done;
  logic              ready;
  logic              fetch_en;
  logic [ADDR_W-1:0] address;
  logic              stall;
  logic              flush;
  logic [DATA_W-1:0] ins_out;
  logic              ins_valid;
  logic              addr_err;
  logic [IDX_W:0]    ld_count;

  modport master (
    output ld_we, ld_addr, ld_data, ld_done, fetch_en, address, stall, flush,
    input  ready, ins_out, ins_valid, addr_err, ld_count
  );

  modport slave (
    input  ld_we, ld_addr, ld_data, ld_done, fetch_en, address, stall, flush,
    output ready, ins_out, ins_valid, addr_err, ld_count
  );
endinterface

// File: rtl/ins_memory_pipe.sv
// Loadable instruction memory with a one-cycle registered fetch port,
// address-error detection and stall/flush control for the IF stage.
module ins_memory_pipe #(
  parameter int unsigned          DATA_W     = 16,
  parameter int unsigned          ADDR_W     = 16,
  parameter int unsigned          DEPTH      = 16,
  parameter int unsigned          BYTE_SHIFT = 2,
  parameter logic [DATA_W-1:0]    NOP_WORD   = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  ins_memory_pipe_if.slave    bus
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = IDX_W + 1;

  typedef enum logic {
    S_LOAD,
    S_RUN
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0]  ld_count_q, ld_count_d;
  logic [DATA_W-1:0] ins_q, ins_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;

  logic              load_we;
  logic [ADDR_W-1:0] idx_full;
  logic              misaligned;
  logic              bad_addr;

  assign load_we = (state_q == S_LOAD) && bus.ld_we;

  // Range check on the full shifted address so out-of-range PCs never alias
  assign idx_full = bus.address >> BYTE_SHIFT;

  if (BYTE_SHIFT > 0) begin : g_align
    assign misaligned = |bus.address[BYTE_SHIFT-1:0];
  end else begin : g_noalign
    assign misaligned = 1'b0;
  end

  assign bad_addr = (idx_full >= ADDR_W'(DEPTH)) || misaligned;

  // Array has no reset so the program survives a reset pulse
  always_ff @(posedge clk) begin
    if (load_we) begin
      mem_q[bus.ld_addr] <= bus.ld_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_LOAD;
      ld_count_q <= '0;
      ins_q      <= NOP_WORD;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ld_count_q <= ld_count_d;
      ins_q      <= ins_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ld_count_d = ld_count_q;
    if (load_we && (ld_count_q != CNT_W'(DEPTH))) begin
      ld_count_d = ld_count_q + 1'b1;
    end
    case (state_q)
      S_LOAD: begin
        if (bus.ld_done || (load_we && (ld_count_d == CNT_W'(DEPTH)))) begin
          state_d = S_RUN;
        end
      end
      S_RUN:   state_d = S_RUN;
      default: state_d = S_LOAD;
    endcase
  end

  // Priority: flush > stall > fetch; LOAD leaves outputs at reset values
  always_comb begin
    ins_d   = ins_q;
    valid_d = valid_q;
    err_d   = err_q;
    if (state_q == S_RUN) begin
      if (bus.flush) begin
        ins_d   = NOP_WORD;
        valid_d = 1'b0;
        err_d   = 1'b0;
      end else if (!bus.stall) begin
        if (!bus.fetch_en) begin
          ins_d   = NOP_WORD;
          valid_d = 1'b0;
          err_d   = 1'b0;
        end else if (bad_addr) begin
          ins_d   = NOP_WORD;
          valid_d = 1'b0;
          err_d   = 1'b1;
        end else begin
          ins_d   = mem_q[idx_full[IDX_W-1:0]];
          valid_d = 1'b1;
          err_d   = 1'b0;
        end
      end
    end
  end

  assign bus.ready     = (state_q == S_RUN);
  assign bus.ins_out   = ins_q;
  assign bus.ins_valid = valid_q;
  assign bus.addr_err  = err_q;
  assign bus.ld_count  = ld_count_q;

endmodule

// File: tb/tb_ins_memory_pipe.sv
// Directed bench for ins_memory_pipe: load, fetch, address errors,
// stall/flush priority and asynchronous reset with program retention.
module tb_ins_memory_pipe;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  ins_memory_pipe_if #(.DATA_W(16), .ADDR_W(16), .DEPTH(16)) bus ();

  ins_memory_pipe #(
    .DATA_W(16), .ADDR_W(16), .DEPTH(16), .BYTE_SHIFT(2), .NOP_WORD(16'h0000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.ld_we    = 1'b0;
    bus.ld_addr  = '0;
    bus.ld_data  = '0;
    bus.ld_done  = 1'b0;
    bus.fetch_en = 1'b0;
    bus.address  = '0;
    bus.stall    = 1'b0;
    bus.flush    = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #3;
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", bus.ready); end
    checks++; if (bus.ins_out !== 16'h0000) begin errors++; $display("FAIL reset_ins got %h exp 0000", bus.ins_out); end
    checks++; if (bus.ins_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.ins_valid); end
    checks++; if (bus.addr_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", bus.addr_err); end
    checks++; if (bus.ld_count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", bus.ld_count); end
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_load_fetch();
    bus.ld_we = 1'b1; bus.ld_addr = 4'd0; bus.ld_data = 16'h0040;
    bus.fetch_en = 1'b1; bus.address = 16'd0;
    step();
    bus.ld_addr = 4'd1; bus.ld_data = 16'h0041;
    step();
    checks++; if (bus.ins_valid !== 1'b0) begin errors++; $display("FAIL load_fetch_ignored got %b exp 0", bus.ins_valid); end
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL load_ready got %b exp 0", bus.ready); end
    bus.ld_we = 1'b0; bus.fetch_en = 1'b0; bus.ld_done = 1'b1;
    step();
    bus.ld_done = 1'b0;
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL done_ready got %b exp 1", bus.ready); end
    checks++; if (bus.ld_count !== 5'd2) begin errors++; $display("FAIL done_count got %0d exp 2", bus.ld_count); end
    bus.fetch_en = 1'b1; bus.address = 16'd0;
    step();
    checks++; if (bus.ins_out !== 16'h0040) begin errors++; $display("FAIL fetch0_ins got %h exp 0040", bus.ins_out); end
    checks++; if (bus.ins_valid !== 1'b1) begin errors++; $display("FAIL fetch0_valid got %b exp 1", bus.ins_valid); end
    bus.address = 16'd4;
    step();
    checks++; if (bus.ins_out !== 16'h0041) begin errors++; $display("FAIL fetch4_ins got %h exp 0041", bus.ins_out); end
    bus.fetch_en = 1'b0;
    step();
    checks++; if (bus.ins_valid !== 1'b0 || bus.ins_out !== 16'h0000) begin errors++; $display("FAIL fetch_idle got %b/%h exp 0/0000", bus.ins_valid, bus.ins_out); end
  endtask

  task automatic test_full_load();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      bus.ld_we = 1'b1; bus.ld_addr = 4'(i); bus.ld_data = 16'h1000 + 16'(i);
      step();
      if (i == 14) begin
        checks++; if (bus.ready !== 1'b0 || bus.ld_count !== 5'd15) begin errors++; $display("FAIL full_15 got %b/%0d exp 0/15", bus.ready, bus.ld_count); end
      end
    end
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL full_ready got %b exp 1", bus.ready); end
    checks++; if (bus.ld_count !== 5'd16) begin errors++; $display("FAIL full_count got %0d exp 16", bus.ld_count); end
    bus.ld_addr = 4'd0; bus.ld_data = 16'hFFFF;
    step();
    bus.ld_we = 1'b0; bus.fetch_en = 1'b1; bus.address = 16'd0;
    step();
    checks++; if (bus.ins_out !== 16'h1000) begin errors++; $display("FAIL protect_ins got %h exp 1000", bus.ins_out); end
    checks++; if (bus.ld_count !== 5'd16) begin errors++; $display("FAIL protect_count got %0d exp 16", bus.ld_count); end
    bus.address = 16'd60;
    step();
    checks++; if (bus.ins_out !== 16'h100F || bus.ins_valid !== 1'b1) begin errors++; $display("FAIL last_word got %h/%b exp 100f/1", bus.ins_out, bus.ins_valid); end
  endtask

  task automatic test_write_with_done();
    do_reset();
    bus.ld_we = 1'b1; bus.ld_addr = 4'd5; bus.ld_data = 16'h5555; bus.ld_done = 1'b1;
    step();
    idle_inputs();
    checks++; if (bus.ready !== 1'b1 || bus.ld_count !== 5'd1) begin errors++; $display("FAIL wdone_state got %b/%0d exp 1/1", bus.ready, bus.ld_count); end
    bus.fetch_en = 1'b1; bus.address = 16'd20;
    step();
    checks++; if (bus.ins_out !== 16'h5555) begin errors++; $display("FAIL wdone_ins got %h exp 5555", bus.ins_out); end
  endtask

  task automatic test_bad_addr();
    bus.fetch_en = 1'b1; bus.address = 16'd64;
    step();
    checks++; if (bus.ins_out !== 16'h0000 || bus.ins_valid !== 1'b0 || bus.addr_err !== 1'b1) begin errors++; $display("FAIL range64 got %h/%b/%b exp 0000/0/1", bus.ins_out, bus.ins_valid, bus.addr_err); end
    bus.address = 16'd6;
    step();
    checks++; if (bus.ins_out !== 16'h0000 || bus.ins_valid !== 1'b0 || bus.addr_err !== 1'b1) begin errors++; $display("FAIL misalign6 got %h/%b/%b exp 0000/0/1", bus.ins_out, bus.ins_valid, bus.addr_err); end
    bus.address = 16'hFFFC;
    step();
    checks++; if (bus.addr_err !== 1'b1) begin errors++; $display("FAIL range_high got %b exp 1", bus.addr_err); end
    bus.address = 16'd4;
    step();
    checks++; if (bus.ins_out !== 16'h1001 || bus.addr_err !== 1'b0) begin errors++; $display("FAIL after_err got %h/%b exp 1001/0", bus.ins_out, bus.addr_err); end
  endtask

  task automatic test_stall();
    bus.fetch_en = 1'b1; bus.address = 16'd8;
    step();
    checks++; if (bus.ins_out !== 16'h1002) begin errors++; $display("FAIL stall_pre got %h exp 1002", bus.ins_out); end
    bus.stall = 1'b1; bus.address = 16'd12;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (bus.ins_out !== 16'h1002 || bus.ins_valid !== 1'b1) begin errors++; $display("FAIL stall_hold%0d got %h/%b exp 1002/1", i, bus.ins_out, bus.ins_valid); end
    end
    bus.stall = 1'b0;
    step();
    checks++; if (bus.ins_out !== 16'h1003) begin errors++; $display("FAIL stall_release got %h exp 1003", bus.ins_out); end
  endtask

  task automatic test_flush();
    bus.fetch_en = 1'b1; bus.address = 16'd8;
    step();
    bus.stall = 1'b1; bus.flush = 1'b1;
    step();
    checks++; if (bus.ins_out !== 16'h0000 || bus.ins_valid !== 1'b0) begin errors++; $display("FAIL flush_stall got %h/%b exp 0000/0", bus.ins_out, bus.ins_valid); end
    bus.stall = 1'b0; bus.flush = 1'b0; bus.address = 16'd6;
    step();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    checks++; if (bus.addr_err !== 1'b0) begin errors++; $display("FAIL flush_err got %b exp 0", bus.addr_err); end
  endtask

  task automatic test_reset_mid_run();
    bus.fetch_en = 1'b1; bus.address = 16'd4;
    step();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.ins_out !== 16'h0000 || bus.ins_valid !== 1'b0 || bus.ready !== 1'b0) begin errors++; $display("FAIL async_clear got %h/%b/%b exp 0000/0/0", bus.ins_out, bus.ins_valid, bus.ready); end
    step();
    rst_n = 1'b1; bus.fetch_en = 1'b0;
    checks++; if (bus.ld_count !== 5'd0) begin errors++; $display("FAIL mid_count got %0d exp 0", bus.ld_count); end
    bus.ld_done = 1'b1;
    step();
    bus.ld_done = 1'b0; bus.fetch_en = 1'b1; bus.address = 16'd0;
    step();
    checks++; if (bus.ins_out !== 16'h1000 || bus.ready !== 1'b1) begin errors++; $display("FAIL retained got %h/%b exp 1000/1", bus.ins_out, bus.ready); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_load_fetch();
    test_full_load();
    test_write_with_done();
    test_bad_addr();
    test_stall();
    test_flush();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ins_memory_pipe.md
Name: ins_memory_pipe

Overview:
Parametrised instruction memory for the pipelined MIPS datapath. It replaces a hard-coded, combinational program store with three things: a loadable array, a one-cycle registered fetch port, and pipeline stall/flush control. After reset, a loader writes the program through a write port. Then the IF stage fetches byte-addressed instructions with address-error detection.

Parameters:
DATA_W, 16, instruction width in bits
ADDR_W, 16, width of fetch and load addresses
DEPTH, 16, number of instruction words (power of two, >=2)
BYTE_SHIFT, 2, right shift converting a byte address to a word index
NOP_WORD, 0, value driven on ins_out when no valid instruction is present

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
ld_we  in  1  loader write strobe
ld_addr  in  $clog2(DEPTH)  loader word index
ld_data  in  DATA_W  loader write data
ld_done  in  1  loader finished; one-cycle pulse
ready  out  1  memory in RUN state, fetches accepted
fetch_en  in  1  IF stage requests an instruction
address  in  ADDR_W  byte address (PC)
stall  in  1  hold the current output (hazard unit)
flush  in  1  squash the current output (branch taken)
ins_out  out  DATA_W  registered instruction
ins_valid  out  1  ins_out holds a fetched, non-squashed instruction
addr_err  out  1  registered with ins_out; the fetch was out of range or misaligned
ld_count  out  $clog2(DEPTH)+1  number of words written since reset

Behaviour:
- Reset (rst_n=0, async):
  - State goes to LOAD; ready=0, ins_out=NOP_WORD, ins_valid=0, addr_err=0, ld_count=0.
  - Array contents are not cleared and are retained across reset.
- State LOAD:
  - ld_we=1 writes ld_data to mem[ld_addr] on the clock edge.
  - ld_count increments per write and saturates at DEPTH.
  - Fetch inputs are ignored; outputs hold their reset values.
  - The machine goes to RUN on the edge where ld_done=1, or on the edge where the write makes ld_count reach DEPTH.
  - A write and ld_done in the same cycle: the write is performed, then the state becomes RUN.
- State RUN:
  - ready=1. ld_we is ignored and the array is write-protected.
  - The machine returns to LOAD only via reset.
- Fetch (RUN only), latency 1:
  - Let idx = address >> BYTE_SHIFT.
  - An address is bad when idx >= DEPTH, or when address[BYTE_SHIFT-1:0] != 0 (misaligned).
  - When fetch_en=1 and stall=0, the next edge loads ins_out=mem[idx], ins_valid=1, addr_err=0.
  - For a bad address, the next edge loads ins_out=NOP_WORD, ins_valid=0, addr_err=1.
  - When fetch_en=0 and stall=0, the next edge loads ins_out=NOP_WORD, ins_valid=0, addr_err=0.
  - When stall=1 (and flush=0), ins_out, ins_valid and addr_err hold, and the address is not sampled.
- Flush:
  - flush=1 forces the next edge to ins_out=NOP_WORD, ins_valid=0, addr_err=0.
  - Priority order is flush > stall > fetch.
- Array width rule:
  - Only the low $clog2(DEPTH) bits of idx address the array.
  - The range check uses the full shifted address, so there is no wrap-around aliasing.
- Reset mid-RUN:
  - Outputs clear immediately (asynchronously) and the state returns to LOAD.
  - The previous program remains in the array. The loader may overwrite it or just pulse ld_done.

Test Plan:
- Reset, write mem[0]=16'h0040 and mem[1]=16'h0041, pulse ld_done; fetch address 0 then 4 -> ins_out is 16'h0040 one cycle after request, then 16'h0041; ins_valid=1, ready=1.
- Write all 16 words without ld_done -> ready rises on the edge after the 16th write; ld_count=16; a 17th ld_we in RUN leaves mem[0] unchanged.
- In RUN, fetch address 64 (idx 16 with DEPTH=16) and address 6 (misaligned) -> ins_out=NOP_WORD, ins_valid=0, addr_err=1 on each.
- Fetch address 8, assert stall for 3 cycles while address changes to 12 -> ins_out holds mem[2] for all 3 cycles; mem[3] appears one cycle after stall drops.
- Assert stall and flush together while ins_out=mem[2] -> next cycle ins_out=NOP_WORD, ins_valid=0.
- Pull rst_n low mid-RUN between clock edges -> outputs clear without a clock edge and ready=0; pulse ld_done only, fetch address 0 -> the old mem[0] value is returned.
